// File: rtl/hazard_controller.sv
// Hazard unit for a 5-stage MIPS pipeline: EX forwarding, WB-to-ID bypass, load-use stall, MEM redirect flush.
// Define HAZARD_STATS_EN to add saturating stall_count/flush_count statistics ports.
module hazard_controller #(
  parameter int STAT_W = 16,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DEST_W-1:0] id_rs,
  input  logic [DEST_W-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [DEST_W-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              mem_redirect,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              id_bypass_a,
  output logic              id_bypass_b,
  output logic              pc_enable,
  output logic              if_id_enable,
  output logic              id_ex_bubble,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_count,
  output logic [STAT_W-1:0] flush_count
`endif
);

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest;
    logic              regwrite;
    logic              memread;
  } slot_t;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t            state, nextState;
  slot_t             exSlot, memSlot, wbSlot;
  logic [DEST_W-1:0] exRs, exRt;
  logic              exUsesRt;
  logic              loadUse, stall;

  // Register 0 is hardwired to zero, so a slot targeting it never produces a value.
  function automatic logic writesReg(slot_t s, logic [DEST_W-1:0] r);
    return s.valid && s.regwrite && (s.dest != '0) && (s.dest == r);
  endfunction

  function automatic logic loadFeeds(slot_t s, logic [DEST_W-1:0] rs,
                                     logic [DEST_W-1:0] rt, logic usesRt);
    return s.valid && s.memread && (s.dest != '0) &&
           ((s.dest == rs) || (usesRt && (s.dest == rt)));
  endfunction

  always_comb begin
    loadUse = loadFeeds(exSlot, id_rs, id_rt, id_uses_rt) ||
              loadFeeds(memSlot, id_rs, id_rt, id_uses_rt);
    stall   = loadUse && !mem_redirect;
  end

  // A load in MEM only has its address in EX/MEM, so it is never a 10 source.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (exSlot.valid) begin
      if (writesReg(memSlot, exRs) && !memSlot.memread)      forward_a = 2'b10;
      else if (writesReg(wbSlot, exRs))                       forward_a = 2'b01;
      if (exUsesRt && writesReg(memSlot, exRt) && !memSlot.memread) forward_b = 2'b10;
      else if (exUsesRt && writesReg(wbSlot, exRt))           forward_b = 2'b01;
    end
  end

  assign id_bypass_a = writesReg(wbSlot, id_rs);
  assign id_bypass_b = writesReg(wbSlot, id_rt);

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    nextState    = RUN;
    pc_enable    = !stall;
    if_id_enable = !stall;
    id_ex_bubble = stall;
    flush_if_id  = mem_redirect;
    flush_id_ex  = mem_redirect;
    flush_ex_mem = mem_redirect;
    case (state)
      RUN, FLUSH: if (mem_redirect) nextState = FLUSH;
                  else if (loadUse) nextState = STALL;
      STALL:      if (mem_redirect) nextState = FLUSH;
                  else if (loadUse) nextState = STALL;
      default:    nextState = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      exSlot   <= '0;
      memSlot  <= '0;
      wbSlot   <= '0;
      exRs     <= '0;
      exRt     <= '0;
      exUsesRt <= 1'b0;
    end else begin
      state    <= nextState;
      wbSlot   <= memSlot;
      memSlot  <= mem_redirect ? '0 : exSlot;
      exSlot   <= (stall || mem_redirect) ? '0
                : slot_t'{valid: 1'b1, dest: id_dest, regwrite: id_regwrite, memread: id_memread};
      exRs     <= id_rs;
      exRt     <= id_rt;
      exUsesRt <= id_uses_rt;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1))        stall_count <= stall_count + 1'b1;
      if (mem_redirect && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: the driver queues hand-computed outputs per cycle,
// a monitor pops and compares them on the falling edge.
module tb_hazard_controller;
  localparam int STAT_W = 16;
  localparam int DEST_W = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DEST_W-1:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic              id_uses_rt = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, mem_redirect = 1'b0;
  logic [1:0]        forward_a, forward_b;
  logic              id_bypass_a, id_bypass_b, pc_enable, if_id_enable, id_ex_bubble;
  logic              flush_if_id, flush_id_ex, flush_ex_mem;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_count, flush_count;
`endif

  hazard_controller #(.STAT_W(STAT_W), .DEST_W(DEST_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .mem_redirect(mem_redirect),
    .forward_a(forward_a), .forward_b(forward_b),
    .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .id_ex_bubble(id_ex_bubble),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ba;
    logic       bb;
    logic       pc;
    logic       ifen;
    logic       bub;
    logic [2:0] fl;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } sb_t;

  sb_t sbq[$];
  int  passCount = 0;
  int  totalCount = 0;

  // Register numbers used by the directed programs.
  localparam logic [4:0] T0 = 5'd8, T1 = 5'd9, T2 = 5'd10, T3 = 5'd11, S0 = 5'd16, S1 = 5'd17;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // stall: pc/IF-ID held and bubble; redir: all flushes with pc enabled.
  function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb,
                              input logic ba, input logic bb,
                              input logic stl, input logic redir);
    exp_t e;
    e.fa = fa; e.fb = fb; e.ba = ba; e.bb = bb;
    e.pc = !stl; e.ifen = !stl; e.bub = stl;
    e.fl = redir ? 3'b111 : 3'b000;
    return e;
  endfunction

  task automatic issue(input string name, input logic rstN,
                       input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                       input logic [4:0] dest, input logic rw, input logic mr,
                       input logic redir, input exp_t e);
    sb_t item;
    @(posedge clk);
    #1;
    reset        = rstN;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = usesRt;
    id_dest      = dest;
    id_regwrite  = rw;
    id_memread   = mr;
    mem_redirect = redir;
    item.name = name;
    item.e    = e;
    sbq.push_back(item);
  endtask

  task automatic nop(input string name, input exp_t e);
    issue(name, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, e);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      sb_t item;
      exp_t act;
      item = sbq.pop_front();
      act  = {forward_a, forward_b, id_bypass_a, id_bypass_b, pc_enable, if_id_enable,
              id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem};
      check(item.name, 32'(act), 32'(item.e));
    end
  end

  initial begin
    exp_t dflt;
    dflt = mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    issue("reset_state", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, dflt);

    // lw $t0 ; add $t1,$t0,$t2 : two stall cycles, then the load value arrives by WB-to-ID bypass.
    issue("lw_issue",   1'b1, S0, T0, 1'b0, T0, 1'b1, 1'b1, 1'b0, dflt);
    issue("lu_stall1",  1'b1, T0, T2, 1'b1, T1, 1'b1, 1'b0, 1'b0, mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    issue("lu_stall2",  1'b1, T0, T2, 1'b1, T1, 1'b1, 1'b0, 1'b0, mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    issue("lu_release", 1'b1, T0, T2, 1'b1, T1, 1'b1, 1'b0, 1'b0, mk(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
    nop("after_lu", dflt);
`ifdef HAZARD_STATS_EN
    check("stall_count_lu", 32'(stall_count), 32'd2);
`endif

    // add $t0,$s0,$s1 ; add $t1,$t0,$t0 : EX/MEM forwarding on both operands.
    issue("add_t0",     1'b1, S0, S1, 1'b1, T0, 1'b1, 1'b0, 1'b0, dflt);
    issue("add_t1",     1'b1, T0, T0, 1'b1, T1, 1'b1, 1'b0, 1'b0, dflt);
    nop("fwd_ex_mem", mk(2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0));

    // add $t0 ; nop ; sub $t2,$t0,$t3 : WB forwarding on rs only.
    issue("add_t0_b",   1'b1, S0, S1, 1'b1, T0, 1'b1, 1'b0, 1'b0, dflt);
    nop("gap_nop", dflt);
    issue("sub_t2",     1'b1, T0, T3, 1'b1, T2, 1'b1, 1'b0, 1'b0, dflt);
    nop("fwd_wb", mk(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

    // Same distance-2 pattern writing $0 : no forwarding.
    issue("add_r0",     1'b1, S0, S1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, dflt);
    nop("gap_nop_r0", dflt);
    issue("sub_from_r0", 1'b1, 5'd0, T3, 1'b1, T2, 1'b1, 1'b0, 1'b0, dflt);
    nop("fwd_r0", dflt);

    // Redirect during a load-use stall: flush wins, stall dropped.
    issue("lw_issue2",  1'b1, S0, T0, 1'b0, T0, 1'b1, 1'b1, 1'b0, dflt);
    issue("lu_stall_bypb", 1'b1, T0, T2, 1'b1, T1, 1'b1, 1'b0, 1'b0, mk(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0));
    issue("redirect",   1'b1, T0, T2, 1'b1, T1, 1'b1, 1'b0, 1'b1, mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    nop("flush_cycle", dflt);
`ifdef HAZARD_STATS_EN
    check("flush_count", 32'(flush_count), 32'd1);
    check("stall_count_redir", 32'(stall_count), 32'd3);
`endif

    // Reset in the second stall cycle abandons the stall; the pending add then issues freely.
    issue("lw_issue3",  1'b1, S0, T0, 1'b0, T0, 1'b1, 1'b1, 1'b0, dflt);
    issue("lu_stall_a", 1'b1, T0, T2, 1'b1, T1, 1'b1, 1'b0, 1'b0, mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    issue("reset_mid_stall", 1'b0, T0, T2, 1'b1, T1, 1'b1, 1'b0, 1'b0, dflt);
`ifdef HAZARD_STATS_EN
    #2;
    check("stall_count_rst", 32'(stall_count), 32'd0);
    check("flush_count_rst", 32'(flush_count), 32'd0);
`endif
    issue("post_reset_no_stall", 1'b1, T0, T2, 1'b1, T1, 1'b1, 1'b0, 1'b0, dflt);
    nop("post_reset_nop", dflt);

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() != 0) check("scoreboard_drain", 32'(sbq.size()), 32'd0);
    #1;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
